nn_infer_ctrl: RTL and testbench

//  Sequencer between nn_memory and the net core. On a start pulse it runs NUM_IMG

---
 rtl/nn_infer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_nn_infer_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_infer_ctrl.sv
// Run sequencer between nn_memory and the net core: feeds NUM_IMG images, collects one
// classified digit per image, and flags length, timeout and protocol errors.
module nn_infer_ctrl #(
   parameter  int outWidth  = 4,
   parameter  int IMG_WORDS = 784,
   parameter  int NUM_IMG   = 1,
   parameter  int TIMEOUT   = 4096,
   localparam int IW        = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic                ren,
   input  logic                mem_valid,
   input  logic                data_last,
   input  logic                net_out_valid,
   input  logic [outWidth-1:0] net_out_data,
   output logic                busy,
   output logic                result_valid,
   output logic [outWidth-1:0] result_digit,
   output logic [IW-1:0]       result_idx,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [2:0]          dbg_state_o
);

   localparam int WW = $clog2(IMG_WORDS + 2);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_LEN   = 2'd1;
   localparam logic [1:0] ERR_TMO   = 2'd2;
   localparam logic [1:0] ERR_PROTO = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FEED = 3'd1,
      S_WAIT = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [WW-1:0]         word_cnt_q, word_cnt_d;
   logic [IW-1:0]         img_cnt_q, img_cnt_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic                  ren_q, ren_d;
   logic                  busy_q, busy_d;
   logic                  result_valid_q, result_valid_d;
   logic [outWidth-1:0]   result_digit_q, result_digit_d;
   logic [IW-1:0]         result_idx_q, result_idx_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [1:0]            err_code_q, err_code_d;

   always_comb begin
      state_d        = state_q;
      word_cnt_d     = word_cnt_q;
      img_cnt_d      = img_cnt_q;
      tmo_cnt_d      = tmo_cnt_q;
      result_valid_d = 1'b0;
      result_digit_d = result_digit_q;
      result_idx_d   = result_idx_q;
      done_d         = 1'b0;
      err_d          = err_q;
      err_code_d     = err_code_q;

      // Abort leaves error/result registers untouched and drops any same-cycle start.
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_FEED;
                  img_cnt_d  = '0;
                  word_cnt_d = '0;
                  err_d      = 1'b0;
                  err_code_d = ERR_NONE;
               end
            end
            S_FEED: begin
               if (net_out_valid) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_PROTO;
               end else if (mem_valid) begin
                  if (word_cnt_q != WW'(IMG_WORDS + 1)) begin
                     word_cnt_d = word_cnt_q + WW'(1);
                  end
                  if (data_last) begin
                     state_d   = S_WAIT;
                     tmo_cnt_d = '0;
                     // Short/long image is reported but the run still collects its result.
                     if ((32'(word_cnt_q) + 32'd1) != 32'(IMG_WORDS)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                     end
                  end
               end
            end
            S_WAIT: begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
               if (net_out_valid) begin
                  result_valid_d = 1'b1;
                  result_digit_d = net_out_data;
                  result_idx_d   = img_cnt_q;
                  if (img_cnt_q == IW'(NUM_IMG - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d    = S_FEED;
                     img_cnt_d  = img_cnt_q + IW'(1);
                     word_cnt_d = '0;
                  end
               end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_TMO;
               end
            end
            S_DONE: begin
               // Only a length error can reach DONE with err set; it suppresses done.
               done_d  = ~err_q;
               state_d = S_IDLE;
            end
            S_ERR: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      ren_d  = (state_d == S_FEED);
      busy_d = (state_d == S_FEED) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         word_cnt_q     <= '0;
         img_cnt_q      <= '0;
         tmo_cnt_q      <= '0;
         ren_q          <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         result_digit_q <= '0;
         result_idx_q   <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         state_q        <= state_d;
         word_cnt_q     <= word_cnt_d;
         img_cnt_q      <= img_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         ren_q          <= ren_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
         result_digit_q <= result_digit_d;
         result_idx_q   <= result_idx_d;
         done_q         <= done_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
      end
   end

   assign ren          = ren_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign result_digit = result_digit_q;
   assign result_idx   = result_idx_q;
   assign done         = done_q;
   assign err          = err_q;
   assign err_code     = err_code_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Directed bench for nn_infer_ctrl: instance a runs single-image runs, instance b runs
// three-image runs with a short timeout; both share the stimulus inputs.
module tb_nn_infer_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       mem_valid;
   logic       data_last;
   logic       net_out_valid;
   logic [3:0] net_out_data;

   logic       ren_a, busy_a, rv_a, done_a, err_a;
   logic [3:0] rd_a;
   logic [0:0] ri_a;
   logic [1:0] ec_a;
   logic [2:0] dbg_a;

   logic       ren_b, busy_b, rv_b, done_b, err_b;
   logic [3:0] rd_b;
   logic [1:0] ri_b;
   logic [1:0] ec_b;
   logic [2:0] dbg_b;

   int total;
   int bad;
   int res_cnt_a;
   int done_cnt_a;
   logic [7:0] exp_q[$];

   nn_infer_ctrl #(.outWidth(4), .IMG_WORDS(784), .NUM_IMG(1), .TIMEOUT(4096)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ren(ren_a),
      .mem_valid(mem_valid), .data_last(data_last), .net_out_valid(net_out_valid),
      .net_out_data(net_out_data), .busy(busy_a), .result_valid(rv_a),
      .result_digit(rd_a), .result_idx(ri_a), .done(done_a), .err(err_a),
      .err_code(ec_a), .dbg_state_o(dbg_a)
   );

   nn_infer_ctrl #(.outWidth(4), .IMG_WORDS(784), .NUM_IMG(3), .TIMEOUT(16)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ren(ren_b),
      .mem_valid(mem_valid), .data_last(data_last), .net_out_valid(net_out_valid),
      .net_out_data(net_out_data), .busy(busy_b), .result_valid(rv_b),
      .result_digit(rd_b), .result_idx(ri_b), .done(done_b), .err(err_b),
      .err_code(ec_b), .dbg_state_o(dbg_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulse counters for instance a, sampled before the edge updates them
   always @(posedge clk) begin
      if (rv_a)   res_cnt_a  <= res_cnt_a + 1;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // driver tasks: all stimulus changes and observations happen on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed(input int n, input int last_at);
      for (int i = 1; i <= n; i++) begin
         mem_valid = 1'b1;
         data_last = (i == last_at);
         step();
      end
      mem_valid = 1'b0;
      data_last = 1'b0;
   endtask

   task automatic net_result(input logic [3:0] d);
      net_out_valid = 1'b1;
      net_out_data  = d;
      step();
      net_out_valid = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   initial begin
      logic [3:0] digs [3];
      int r0;
      int d0;
      digs = '{4'd2, 4'd5, 4'd9};
      total = 0; bad = 0; res_cnt_a = 0; done_cnt_a = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_valid = 1'b0; data_last = 1'b0;
      net_out_valid = 1'b0; net_out_data = '0;
      repeat (3) step();
      check("rst_ren",   32'(ren_a),  32'd0);
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_err",   32'(err_b),  32'd0);
      check("rst_state", 32'(dbg_b),  32'd0);
      rst_n = 1'b1;
      step();

      // 1: single image, digit 7
      pulse_start();
      check("t1_ren_up",  32'(ren_a),  32'd1);
      check("t1_busy_up", 32'(busy_a), 32'd1);
      feed(784, 784);
      check("t1_ren_wait",  32'(ren_a),  32'd0);
      check("t1_busy_wait", 32'(busy_a), 32'd1);
      r0 = res_cnt_a;
      repeat (5) step();
      net_result(4'd7);
      check("t1_rv",    32'(rv_a), 32'd1);
      check("t1_digit", 32'(rd_a), 32'd7);
      check("t1_idx",   32'(ri_a), 32'd0);
      step();
      check("t1_done",  32'(done_a), 32'd1);
      check("t1_rv_lo", 32'(rv_a),   32'd0);
      check("t1_err",   32'(err_a),  32'd0);
      step();
      check("t1_done_lo", 32'(done_a), 32'd0);
      check("t1_one_res", 32'(res_cnt_a - r0), 32'd1);
      do_abort();

      // 2: three images on b, digits 2,5,9
      for (int k = 0; k < 3; k++) exp_q.push_back({2'b00, 2'(k), digs[k]});
      pulse_start();
      check("t2_busy", 32'(busy_b), 32'd1);
      for (int k = 0; k < 3; k++) begin
         feed(784, 784);
         check("t2_ren_wait", 32'(ren_b), 32'd0);
         repeat (3) step();
         net_result(digs[k]);
         check("t2_rv", 32'(rv_b), 32'd1);
         check("t2_res", 32'({2'b00, ri_b, rd_b}), 32'(exp_q.pop_front()));
         step();
         if (k < 2) begin
            check("t2_no_done", 32'(done_b), 32'd0);
            check("t2_ren_back", 32'(ren_b), 32'd1);
         end else begin
            check("t2_done", 32'(done_b), 32'd1);
         end
      end
      step();

      // 3: short image on a
      pulse_start();
      feed(700, 700);
      check("t3_err",  32'(err_a), 32'd1);
      check("t3_code", 32'(ec_a),  32'd1);
      check("t3_ren",  32'(ren_a), 32'd0);
      repeat (2) step();
      net_result(4'd3);
      check("t3_rv",    32'(rv_a), 32'd1);
      check("t3_digit", 32'(rd_a), 32'd3);
      step();
      check("t3_no_done",  32'(done_a), 32'd0);
      check("t3_err_hold", 32'(err_a),  32'd1);
      do_abort();
      check("t3_abort_err",  32'(err_b), 32'd1);
      check("t3_abort_code", 32'(ec_b),  32'd1);

      // 4: timeout on b
      pulse_start();
      check("t4_clr_err",  32'(err_b), 32'd0);
      check("t4_clr_code", 32'(ec_b),  32'd0);
      feed(784, 784);
      repeat (15) step();
      check("t4_pre_err",  32'(err_b),  32'd0);
      check("t4_pre_busy", 32'(busy_b), 32'd1);
      step();
      check("t4_err",   32'(err_b),  32'd1);
      check("t4_code",  32'(ec_b),   32'd2);
      check("t4_ren",   32'(ren_b),  32'd0);
      check("t4_busy",  32'(busy_b), 32'd0);
      check("t4_state", 32'(dbg_b),  32'd4);
      step();
      check("t4_idle",     32'(dbg_b), 32'd0);
      check("t4_err_hold", 32'(err_b), 32'd1);
      pulse_start();
      check("t4_restart_err", 32'(err_b),  32'd0);
      check("t4_restart_bsy", 32'(busy_b), 32'd1);
      do_abort();

      // 5: start while busy is ignored, then abort mid-feed
      pulse_start();
      feed(400, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t5_busy", 32'(busy_a), 32'd1);
      feed(384, 384);
      check("t5_no_len_err", 32'(err_a), 32'd0);
      check("t5_ren_wait",   32'(ren_a), 32'd0);
      net_result(4'd4);
      check("t5_digit", 32'(rd_a), 32'd4);
      step();
      check("t5_done", 32'(done_a), 32'd1);
      step();
      r0 = res_cnt_a;
      d0 = done_cnt_a;
      pulse_start();
      feed(100, 0);
      check("t5_ren_feed", 32'(ren_a), 32'd1);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("t5_abort_ren",  32'(ren_a),  32'd0);
      check("t5_abort_busy", 32'(busy_a), 32'd0);
      repeat (3) step();
      check("t5_start_drop", 32'(dbg_a), 32'd0);
      check("t5_no_res",  32'(res_cnt_a - r0),  32'd0);
      check("t5_no_done", 32'(done_cnt_a - d0), 32'd0);

      // 6: reset mid-run, clean rerun, protocol error
      pulse_start();
      feed(10, 10);
      check("t6_pre_err",  32'(err_a),  32'd1);
      check("t6_pre_busy", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_err",  32'(err_a),  32'd0);
      check("t6_rst_code", 32'(ec_a),   32'd0);
      check("t6_rst_busy", 32'(busy_a), 32'd0);
      check("t6_rst_ren",  32'(ren_a),  32'd0);
      step();
      rst_n = 1'b1;
      step();
      pulse_start();
      feed(784, 784);
      repeat (5) step();
      net_result(4'd6);
      check("t6_rv",    32'(rv_a), 32'd1);
      check("t6_digit", 32'(rd_a), 32'd6);
      step();
      check("t6_done", 32'(done_a), 32'd1);
      check("t6_err",  32'(err_a),  32'd0);
      step();
      pulse_start();
      feed(5, 0);
      net_out_valid = 1'b1;
      step();
      net_out_valid = 1'b0;
      check("t6_proto_err",  32'(err_a),  32'd1);
      check("t6_proto_code", 32'(ec_a),   32'd3);
      check("t6_proto_busy", 32'(busy_a), 32'd0);
      check("t6_proto_ren",  32'(ren_a),  32'd0);
      repeat (2) step();

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
